div_ctrl: RTL and testbench

Sequencing front-end for the iterative 32-bit integer divider, placed between the execute-stage issue logic and the divider core. Accepts DIV/DIVU/REM/REMU requests over a valid/ready handshake and drives the divider's operand, start, sign and stall controls. Captures the result on the divider's done pulse, selects the quotient or remainder, and holds it in a response register until the writeback stage consumes it. Supports pipeline flush and stall.

---
 rtl/div_pkg.sv | 31 +++
 rtl/div_result_cache.sv | 58 +++++
 rtl/div_ctrl.sv | 151 +++++++++++++++
 tb/tb_div_ctrl.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the divider sequencing front-end.
package div_pkg;

    localparam int DIV_XLEN = 32;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        LOAD = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } div_ctrl_state_e;

    // DIV and REM treat their operands as two's complement.
    function automatic logic op_is_signed(input div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    // REM and REMU return the remainder, the others the quotient.
    function automatic logic op_is_rem(input div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_result_cache.sv
// Single-entry cache of the last completed division (operands, signedness,
// quotient and remainder). Compiled only when DIV_RESULT_CACHE_EN is defined.
`ifdef DIV_RESULT_CACHE_EN
module div_result_cache
    import div_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                invalidate,
    input  logic                wr_en,
    input  logic [DIV_XLEN-1:0] wr_a,
    input  logic [DIV_XLEN-1:0] wr_b,
    input  logic                wr_sign,
    input  logic [DIV_XLEN-1:0] wr_quot,
    input  logic [DIV_XLEN-1:0] wr_rem,
    input  logic [DIV_XLEN-1:0] rd_a,
    input  logic [DIV_XLEN-1:0] rd_b,
    input  logic                rd_sign,
    output logic                hit,
    output logic [DIV_XLEN-1:0] hit_quot,
    output logic [DIV_XLEN-1:0] hit_rem
);

    logic                entry_valid;
    logic [DIV_XLEN-1:0] entry_a;
    logic [DIV_XLEN-1:0] entry_b;
    logic                entry_sign;
    logic [DIV_XLEN-1:0] entry_quot;
    logic [DIV_XLEN-1:0] entry_rem;

    // Entry storage; invalidation wins over a write in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_valid <= 1'b0;
            entry_a     <= '0;
            entry_b     <= '0;
            entry_sign  <= 1'b0;
            entry_quot  <= '0;
            entry_rem   <= '0;
        end else if (invalidate) begin
            entry_valid <= 1'b0;
        end else if (wr_en) begin
            entry_valid <= 1'b1;
            entry_a     <= wr_a;
            entry_b     <= wr_b;
            entry_sign  <= wr_sign;
            entry_quot  <= wr_quot;
            entry_rem   <= wr_rem;
        end
    end

    assign hit      = entry_valid && (entry_a == rd_a) && (entry_b == rd_b)
                      && (entry_sign == rd_sign);
    assign hit_quot = entry_quot;
    assign hit_rem  = entry_rem;

endmodule
`endif

// File: rtl/div_ctrl.sv
// Sequencing front-end for the iterative 32-bit divider: accepts
// DIV/DIVU/REM/REMU requests, drives the divider controls, captures the
// selected result and holds it until writeback takes it.
// Optional: define DIV_RESULT_CACHE_EN to add a last-result cache that lets
// a repeat of the previous operands skip the divider entirely.
//
// state | meaning
// IDLE  | ready for a request
// PREP  | operands driven, start low so the divider sizes a stable dividend
// LOAD  | start high, divider latches the operands
// WAIT  | start held high until the divider's done pulse
// RESP  | result held on the response port until consumed
module div_ctrl
    import div_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_op_i,
    input  logic [DIV_XLEN-1:0] req_a_i,
    input  logic [DIV_XLEN-1:0] req_b_i,
    input  logic [TAG_W-1:0]    req_tag_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DIV_XLEN-1:0] rsp_data_o,
    output logic [TAG_W-1:0]    rsp_tag_o,
    input  logic                flush_i,
    input  logic                stall_i,
    output logic                busy_o,
    output logic                div_start_o,
    output logic                div_sign_o,
    output logic [DIV_XLEN-1:0] div_dividend_o,
    output logic [DIV_XLEN-1:0] div_divider_o,
    output logic                div_stall_o,
    input  logic [DIV_XLEN-1:0] div_quotient_i,
    input  logic [DIV_XLEN-1:0] div_remainder_i,
    input  logic                div_valid_i
);

    div_ctrl_state_e     state;
    div_ctrl_state_e     state_next;
    logic [DIV_XLEN-1:0] a_q;
    logic [DIV_XLEN-1:0] b_q;
    div_op_e             op_q;
    logic [TAG_W-1:0]    tag_q;
    logic [DIV_XLEN-1:0] result_q;

    logic                accept;
    logic                capture;
    logic                cache_hit;
    logic [DIV_XLEN-1:0] cache_result;

    assign req_ready_o = (state == IDLE) && !flush_i;
    assign accept      = req_valid_i && req_ready_o;
    // The divider reports valid while idle, so only a WAIT-state pulse counts.
    assign capture     = (state == WAIT) && div_valid_i && !stall_i && !flush_i;
    assign div_stall_o = stall_i;

`ifdef DIV_RESULT_CACHE_EN
    logic [DIV_XLEN-1:0] hit_quot;
    logic [DIV_XLEN-1:0] hit_rem;

    div_result_cache u_cache (
        .clk        (clk_i),
        .rst_n      (reset_i),
        .invalidate (flush_i),
        .wr_en      (capture),
        .wr_a       (a_q),
        .wr_b       (b_q),
        .wr_sign    (op_is_signed(op_q)),
        .wr_quot    (div_quotient_i),
        .wr_rem     (div_remainder_i),
        .rd_a       (req_a_i),
        .rd_b       (req_b_i),
        .rd_sign    (op_is_signed(div_op_e'(req_op_i))),
        .hit        (cache_hit),
        .hit_quot   (hit_quot),
        .hit_rem    (hit_rem)
    );

    assign cache_result = op_is_rem(div_op_e'(req_op_i)) ? hit_rem : hit_quot;
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides everything, stall freezes the divider phases.
    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept)      state_next = cache_hit ? RESP : PREP;
                PREP:    if (!stall_i)    state_next = LOAD;
                LOAD:    if (!stall_i)    state_next = WAIT;
                WAIT:    if (capture)     state_next = RESP;
                RESP:    if (rsp_ready_i) state_next = IDLE;
                default:                  state_next = IDLE;
            endcase
        end
    end

    // Control outputs decoded from the current state.
    always_comb begin
        busy_o      = (state != IDLE);
        rsp_valid_o = (state == RESP);
        div_start_o = (state == LOAD) || (state == WAIT);
        div_sign_o  = ((state == PREP) || (state == LOAD) || (state == WAIT))
                      && op_is_signed(op_q);
    end

    // Request capture on accept, result capture on the divider's done pulse.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= DIV;
            tag_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            a_q   <= req_a_i;
            b_q   <= req_b_i;
            op_q  <= div_op_e'(req_op_i);
            tag_q <= req_tag_i;
            if (cache_hit) begin
                result_q <= cache_result;
            end
        end else if (capture) begin
            result_q <= op_is_rem(op_q) ? div_remainder_i : div_quotient_i;
        end
    end

    assign div_dividend_o = a_q;
    assign div_divider_o  = b_q;
    assign rsp_data_o     = result_q;
    assign rsp_tag_o      = tag_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl with a behavioural divider core model.
module tb_div_ctrl;
    import div_pkg::*;

`ifdef DIV_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk_i;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [31:0] req_a_i;
    logic [31:0] req_b_i;
    logic [4:0]  req_tag_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [4:0]  rsp_tag_o;
    logic        flush_i;
    logic        stall_i;
    logic        busy_o;
    logic        div_start_o;
    logic        div_sign_o;
    logic [31:0] div_dividend_o;
    logic [31:0] div_divider_o;
    logic        div_stall_o;
    logic [31:0] div_quotient_i;
    logic [31:0] div_remainder_i;
    logic        div_valid_i;

    int errors = 0;
    int checks = 0;

    // Bench view of the result cache (only used when CACHE is set).
    bit          c_valid = 1'b0;
    logic [31:0] c_a, c_b;
    bit          c_s;

    div_ctrl #(.TAG_W(5)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_a_i        (req_a_i),
        .req_b_i        (req_b_i),
        .req_tag_i      (req_tag_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_data_o     (rsp_data_o),
        .rsp_tag_o      (rsp_tag_o),
        .flush_i        (flush_i),
        .stall_i        (stall_i),
        .busy_o         (busy_o),
        .div_start_o    (div_start_o),
        .div_sign_o     (div_sign_o),
        .div_dividend_o (div_dividend_o),
        .div_divider_o  (div_divider_o),
        .div_stall_o    (div_stall_o),
        .div_quotient_i (div_quotient_i),
        .div_remainder_i(div_remainder_i),
        .div_valid_i    (div_valid_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Architectural division result (RISC-V M semantics).
    function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Divider bit count: max(3, bit length of |dividend|), 3 for special cases.
    function automatic int ref_k(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag;
        int bl;
        if (b == 32'd0) return 3;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 3;
        mag = (sgn && a[31]) ? (32'd0 - a) : a;
        bl = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) bl = i + 1;
        return (bl < 3) ? 3 : bl;
    endfunction

    // Divider core model: latches on the first cycle of start, counts k
    // unstalled cycles, pulses valid once; reports valid whenever idle.
    logic        d_active, d_fired;
    int          d_cnt;
    logic [31:0] d_q, d_r;
    always @(posedge clk_i or negedge reset_i) begin : divider_model
        logic [31:0] tq, tr;
        if (!reset_i) begin
            d_active <= 1'b0;
            d_fired  <= 1'b0;
            d_cnt    <= 0;
            d_q      <= 32'd0;
            d_r      <= 32'd0;
        end else if (!div_start_o) begin
            d_active <= 1'b0;
            d_fired  <= 1'b0;
        end else if (!d_active) begin
            ref_div(div_sign_o, div_dividend_o, div_divider_o, tq, tr);
            d_q      <= tq;
            d_r      <= tr;
            d_cnt    <= ref_k(div_sign_o, div_dividend_o, div_divider_o);
            d_active <= 1'b1;
        end else if (!div_stall_o) begin
            if (d_cnt != 0) d_cnt <= d_cnt - 1;
            else            d_fired <= 1'b1;
        end
    end
    assign div_valid_i     = div_start_o ? (d_active && d_cnt == 0 && !d_fired && !div_stall_o) : 1'b1;
    assign div_quotient_i  = d_q;
    assign div_remainder_i = d_r;

    function automatic logic [31:0] expect_data(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        ref_div(op == DIV || op == REM, a, b, q, r);
        return (op == REM || op == REMU) ? r : q;
    endfunction

    // Issue one request from a negedge and wait (bounded) for the response.
    // Latency is counted in cycles from the accept cycle (cycle 0).
    task automatic run_op(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input int stall_at, input int stall_len,
                          output logic [31:0] data, output logic [4:0] tag_seen,
                          output int lat, output int exp_lat, output logic sign_seen);
        bit sgn, hit;
        sgn = (op == DIV || op == REM);
        hit = CACHE && c_valid && c_a == a && c_b == b && c_s == sgn;
        exp_lat = hit ? 1 : ref_k(sgn, a, b) + 4;
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_a_i     = a;
        req_b_i     = b;
        req_tag_i   = tag;
        lat = 0;
        sign_seen = 1'b0;
        do begin
            @(negedge clk_i);
            lat++;
            if (lat == 1) req_valid_i = 1'b0;
            if (lat == 2) sign_seen = div_sign_o;
            stall_i = (stall_len > 0 && lat >= stall_at && lat < stall_at + stall_len);
        end while (!rsp_valid_o && lat < 300);
        stall_i  = 1'b0;
        data     = rsp_data_o;
        tag_seen = rsp_tag_o;
        if (CACHE && !hit && rsp_valid_o) begin
            c_valid = 1'b1;
            c_a = a;
            c_b = b;
            c_s = sgn;
        end
    endtask

    task automatic consume();
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({rsp_valid_o, busy_o, div_start_o, div_sign_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {rsp_valid_o, busy_o, div_start_o, div_sign_o});
        end
        checks++;
        if ({div_dividend_o, div_divider_o, rsp_data_o, rsp_tag_o} !== '0) begin
            errors++;
            $display("FAIL reset_regs: got %h %h %h %h expected zeros", div_dividend_o, div_divider_o, rsp_data_o, rsp_tag_o);
        end
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", req_ready_o);
        end
        reset_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_basic();
        logic [31:0] d; logic [4:0] t; int lat, el; logic s;
        run_op(DIVU, 32'd100, 32'd7, 5'd5, 0, 0, d, t, lat, el, s);
        checks++;
        if (d !== 32'd14 || t !== 5'd5) begin
            errors++;
            $display("FAIL divu_basic: got data=%0d tag=%0d expected data=14 tag=5", d, t);
        end
        checks++;
        if (lat != 11) begin
            errors++;
            $display("FAIL divu_latency: got %0d expected 11", lat);
        end
        checks++;
        if (s !== 1'b0) begin
            errors++;
            $display("FAIL divu_sign: got %b expected 0", s);
        end
        consume();
        run_op(REMU, 32'd100, 32'd7, 5'd6, 0, 0, d, t, lat, el, s);
        checks++;
        if (d !== 32'd2 || t !== 5'd6 || lat != el) begin
            errors++;
            $display("FAIL remu_after_divu: got data=%0d tag=%0d lat=%0d expected data=2 tag=6 lat=%0d", d, t, lat, el);
        end
        consume();
    endtask

    // Signed cases and divider special cases from constant tables.
    task automatic test_signed_special();
        div_op_e     ov[7] = '{DIV, REM, DIV, DIVU, REMU, DIV, REM};
        logic [31:0] av[7] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv[7] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev[7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] d; logic [4:0] t; int lat, el; logic s;
        for (int i = 0; i < 7; i++) begin
            run_op(ov[i], av[i], bv[i], 5'(i + 10), 0, 0, d, t, lat, el, s);
            checks++;
            if (d !== ev[i] || t !== 5'(i + 10) || lat != el) begin
                errors++;
                $display("FAIL special_%0d: got data=%h tag=%0d lat=%0d expected data=%h tag=%0d lat=%0d",
                         i, d, t, lat, ev[i], i + 10, el);
            end
            if (el != 1) begin
                checks++;
                if (s !== (ov[i] == DIV || ov[i] == REM)) begin
                    errors++;
                    $display("FAIL sign_%0d: got %b expected %b", i, s, ov[i] == DIV || ov[i] == REM);
                end
            end
            consume();
        end
    endtask

    task automatic test_stall();
        logic [31:0] d; logic [4:0] t; int lat, el; logic s;
        stall_i = 1'b1;
        #1;
        checks++;
        if (div_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_mirror: got %b expected 1", div_stall_o);
        end
        @(negedge clk_i);
        stall_i = 1'b0;
        run_op(DIVU, 32'd200, 32'd7, 5'd3, 4, 4, d, t, lat, el, s);
        checks++;
        if (d !== 32'd28 || lat != el + 4) begin
            errors++;
            $display("FAIL stall_wait: got data=%0d lat=%0d expected data=28 lat=%0d", d, lat, el + 4);
        end
        consume();
    endtask

    task automatic test_hold();
        logic [31:0] d; logic [4:0] t; int lat, el; logic s; bit ok;
        run_op(DIVU, 32'd1000, 32'd9, 5'd9, 0, 0, d, t, lat, el, s);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (!rsp_valid_o || rsp_data_o !== 32'd111 || rsp_tag_o !== 5'd9 || req_ready_o !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rsp_hold: got valid=%b data=%0d tag=%0d ready=%b expected 1 111 9 0",
                     rsp_valid_o, rsp_data_o, rsp_tag_o, req_ready_o);
        end
        consume();
        checks++;
        if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rsp_release: got valid=%b busy=%b expected 0 0", rsp_valid_o, busy_o);
        end
    endtask

    task automatic test_flush();
        logic [31:0] d; logic [4:0] t; int lat, el; logic s; bit seen;
        run_op(DIVU, 32'd9, 32'd3, 5'd1, 0, 0, d, t, lat, el, s);
        consume();
        req_valid_i = 1'b1; req_op_i = DIVU; req_a_i = 32'd100000; req_b_i = 32'd3; req_tag_i = 5'd2;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b1 || div_start_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre: got busy=%b start=%b expected 1 1", busy_o, div_start_o);
        end
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        c_valid = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || div_start_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: got busy=%b start=%b valid=%b expected 0 0 0", busy_o, div_start_o, rsp_valid_o);
        end
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk_i);
            if (rsp_valid_o) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_stale: got response expected none");
        end
        run_op(DIVU, 32'd9, 32'd3, 5'd4, 0, 0, d, t, lat, el, s);
        checks++;
        if (d !== 32'd3 || t !== 5'd4 || lat != 8) begin
            errors++;
            $display("FAIL flush_reissue: got data=%0d tag=%0d lat=%0d expected 3 4 8", d, t, lat);
        end
        consume();
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            if (rsp_valid_o) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_single: got extra response expected none");
        end
        // Flush in the same cycle as a request: not accepted.
        req_valid_i = 1'b1; req_a_i = 32'd50; req_b_i = 32'd5; flush_i = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_req_ready: got %b expected 0", req_ready_o);
        end
        @(negedge clk_i);
        req_valid_i = 1'b0; flush_i = 1'b0;
        c_valid = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_req_accept: got busy=%b expected 0", busy_o);
        end
        // Flush together with rsp_ready in RESP drops the response.
        run_op(DIV, 32'd77, 32'd7, 5'd7, 0, 0, d, t, lat, el, s);
        flush_i = 1'b1; rsp_ready_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0; rsp_ready_i = 1'b0;
        c_valid = 1'b0;
        checks++;
        if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || d !== 32'd11) begin
            errors++;
            $display("FAIL flush_resp: got valid=%b busy=%b data=%0d expected 0 0 11", rsp_valid_o, busy_o, d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [4:0] t; int lat, el; logic s;
        req_valid_i = 1'b1; req_op_i = DIVU; req_a_i = 32'd100000; req_b_i = 32'd3; req_tag_i = 5'd8;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        checks++;
        if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || div_start_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got valid=%b busy=%b start=%b expected 0 0 0", rsp_valid_o, busy_o, div_start_o);
        end
        @(negedge clk_i);
        reset_i = 1'b1;
        c_valid = 1'b0;
        @(negedge clk_i);
        run_op(DIVU, 32'd10, 32'd3, 5'd12, 0, 0, d, t, lat, el, s);
        checks++;
        if (d !== 32'd3 || t !== 5'd12 || lat != 8) begin
            errors++;
            $display("FAIL reset_reissue: got data=%0d tag=%0d lat=%0d expected 3 12 8", d, t, lat);
        end
        consume();
    endtask

    task automatic test_random();
        logic [31:0] a, b, pa, pb, d, e; logic [4:0] tag, t; int lat, el; logic s;
        div_op_e op;
        pa = 32'd1; pb = 32'd1;
        for (int n = 0; n < 30; n++) begin
            op = div_op_e'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       a = $urandom;
                1:       a = $urandom_range(0, 255);
                2:       a = 32'h8000_0000;
                default: a = 32'd0 - 32'($urandom_range(1, 1000));
            endcase
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom;
                default: b = $urandom_range(1, 50);
            endcase
            if ($urandom_range(0, 3) == 0) begin
                a = pa; b = pb;
            end
            tag = 5'($urandom_range(0, 31));
            e = expect_data(op, a, b);
            run_op(op, a, b, tag, 0, 0, d, t, lat, el, s);
            checks++;
            if (d !== e || t !== tag || lat != el) begin
                errors++;
                $display("FAIL random_%0d: op=%0d a=%h b=%h got data=%h tag=%0d lat=%0d expected data=%h tag=%0d lat=%0d",
                         n, op, a, b, d, t, lat, e, tag, el);
            end
            consume();
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            pa = a; pb = b;
        end
    endtask

    initial begin
        reset_i = 1'b0; req_valid_i = 1'b0; req_op_i = 2'd0; req_a_i = 32'd0; req_b_i = 32'd0;
        req_tag_i = 5'd0; rsp_ready_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_basic();
        test_signed_special();
        test_stall();
        test_hold();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
